alu_based_stack: RTL and testbench

//  Synchronous LIFO of signed words with a built-in ALU that adds or multiplies the top two entries.
//  It is the execution engine of the postfix-expression evaluator. A sequencer issues one opcode per clock.

---
 rtl/stack_pkg.sv | 12 +
 rtl/alu_based_stack_if.sv | 11 +
 rtl/stack_alu.sv | 20 ++
 rtl/alu_based_stack.sv | 59 +++++
 tb/tb_alu_based_stack.sv | 134 +++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: opcode encodings shared by the stack engine, its ALU and the interface.
package stack_pkg;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    function automatic logic is_arith(input logic [2:0] op);
        return op == OP_ADD || op == OP_MUL;
    endfunction
endpackage

// File: rtl/alu_based_stack_if.sv
// alu_based_stack_if: opcode/operand bus from the sequencer and registered results back.
interface alu_based_stack_if #(parameter int N = 8);
    logic [2:0]          opcode;
    logic signed [N-1:0] input_data;
    logic signed [N-1:0] output_data;
    logic                overflow;
    logic                success;

    modport master (output opcode, input_data, input output_data, overflow, success);
    modport slave  (input opcode, input_data, output output_data, overflow, success);
endinterface

// File: rtl/stack_alu.sv
// stack_alu: combinational add/multiply of the top two stack entries with signed overflow detect.
module stack_alu import stack_pkg::*; #(parameter int N = 8) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic [2:0]          op,
    output logic signed [N-1:0] res,
    output logic                ovf
);
    logic signed [N-1:0]   sum;
    logic signed [2*N-1:0] prod;

    always_comb begin
        sum  = a + b;
        prod = a * b;
        res  = op == OP_MUL ? prod[N-1:0] : sum;
        // Product fits in N bits only when its upper N+1 bits are a pure sign extension
        ovf  = op == OP_MUL ? !(&prod[2*N-1:N-1] || !(|prod[2*N-1:N-1]))
                            : (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    end
endmodule

// File: rtl/alu_based_stack.sv
// alu_based_stack: signed LIFO with an in-place ADD/MUL on the top two entries.
// One opcode per clock; results and status are registered.
module alu_based_stack import stack_pkg::*; #(parameter int N = 8, parameter int DEPTH = 8) (
    input logic               clk,
    input logic               rst,
    alu_based_stack_if.slave  bus
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic signed [N-1:0] mem [DEPTH];
    logic [SW-1:0]       sp;
    logic [AW-1:0]       top_idx, next_idx, push_idx;
    logic signed [N-1:0] alu_res, data_q;
    logic                alu_ovf, ovf_q, suc_q;
    logic                arith, push, pop, legal;

    always_comb begin
        arith    = is_arith(bus.opcode);
        push     = bus.opcode == OP_PUSH;
        pop      = bus.opcode == OP_POP;
        legal    = arith ? sp > SW'(1) : push ? sp < SW'(DEPTH) : pop ? sp != '0 : 1'b0;
        // Indices only matter when the op is legal, so truncation is safe
        top_idx  = AW'(sp - SW'(1));
        next_idx = AW'(sp - SW'(2));
        push_idx = AW'(sp);
    end

    stack_alu #(.N(N)) u_alu (
        .a   (mem[top_idx]),
        .b   (mem[next_idx]),
        .op  (bus.opcode),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    always_ff @(posedge clk)
        if (legal && push) mem[push_idx] <= bus.input_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp     <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            suc_q  <= 1'b0;
        end else begin
            suc_q <= legal;
            ovf_q <= legal && arith && alu_ovf;
            if (legal) begin
                data_q <= arith ? alu_res : pop ? mem[top_idx] : data_q;
                sp     <= push ? sp + SW'(1) : pop ? sp - SW'(1) : sp;
            end
        end
    end

    assign bus.output_data = data_q;
    assign bus.overflow    = ovf_q;
    assign bus.success     = suc_q;
endmodule

// File: tb/tb_alu_based_stack.sv
// tb_alu_based_stack: directed and random opcode sequences checked against a queue-based model.
module tb_alu_based_stack;
    import stack_pkg::*;

    localparam int N = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int   q[$];
    int   exp_out = 0;
    logic exp_ovf = 1'b0;
    logic exp_suc = 1'b0;

    alu_based_stack_if #(.N(N)) bus ();
    alu_based_stack #(N, DEPTH) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int wrap(input int r);
        logic signed [7:0] t;
        t = r[7:0];
        return int'(t);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"}, int'(bus.output_data), exp_out);
        chk({tag, ".ovf"}, int'(bus.overflow), int'(exp_ovf));
        chk({tag, ".suc"}, int'(bus.success), int'(exp_suc));
    endtask

    task automatic do_op(input logic [2:0] o, input int d, input string tag);
        int a, b, r;
        bus.opcode = o;
        bus.input_data = d[7:0];
        @(posedge clk);
        exp_ovf = 1'b0;
        exp_suc = 1'b0;
        if ((o == OP_ADD || o == OP_MUL) && q.size() >= 2) begin
            a = q[q.size()-1];
            b = q[q.size()-2];
            r = o == OP_ADD ? a + b : a * b;
            exp_out = wrap(r);
            exp_ovf = r < -128 || r > 127;
            exp_suc = 1'b1;
        end else if (o == OP_PUSH && q.size() < DEPTH) begin
            q.push_back(wrap(d));
            exp_suc = 1'b1;
        end else if (o == OP_POP && q.size() > 0) begin
            exp_out = q.pop_back();
            exp_suc = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.opcode = OP_NOP;
        bus.input_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        do_op(OP_POP, 0, "pop_empty");
        do_op(OP_PUSH, 3, "push3");
        do_op(OP_PUSH, 4, "push4");
        do_op(OP_ADD, 0, "add");
        chk("add_is_7", int'(bus.output_data), 7);
        do_op(OP_POP, 0, "pop4");
        do_op(OP_POP, 0, "pop3");
        do_op(OP_PUSH, 7, "push7");
        do_op(OP_POP, 0, "pop7");
        chk("pop_is_7", int'(bus.output_data), 7);
        do_op(OP_PUSH, -5, "push_m5");
        do_op(OP_PUSH, 6, "push6");
        do_op(OP_MUL, 0, "mul_m30");
        chk("mul_is_m30", int'(bus.output_data), -30);
        do_op(OP_PUSH, 100, "push100");
        do_op(OP_PUSH, 2, "push2");
        do_op(OP_MUL, 0, "mul_wrap");
        chk("mul_wrap_val", int'(bus.output_data), -56);
        chk("mul_wrap_ovf", int'(bus.overflow), 1);
        repeat (4) do_op(OP_POP, 0, "drain");
        do_op(OP_PUSH, 100, "push100a");
        do_op(OP_PUSH, 100, "push100b");
        do_op(OP_ADD, 0, "add_ovf");
        chk("add_ovf_val", int'(bus.output_data), -56);
        chk("add_ovf_flag", int'(bus.overflow), 1);
        do_op(OP_NOP, 0, "nop");
        chk("nop_ovf", int'(bus.overflow), 0);
        chk("nop_data", int'(bus.output_data), -56);
        repeat (2) do_op(OP_POP, 0, "drain2");
        for (int i = 1; i <= 4; i++) do_op(OP_PUSH, i, "fill");
        do_op(OP_PUSH, 9, "push_full");
        chk("push_full_suc", int'(bus.success), 0);
        for (int i = 4; i >= 1; i--) begin
            do_op(OP_POP, 0, "unfill");
            chk("unfill_val", int'(bus.output_data), i);
        end
        do_op(OP_POP, 0, "pop_under");
        chk("pop_under_suc", int'(bus.success), 0);
        do_op(OP_PUSH, 1, "push1");
        do_op(OP_ADD, 0, "add_short");
        chk("add_short_data", int'(bus.output_data), 1);
        #2 rst = 1'b1;
        #1;
        q.delete();
        exp_out = 0;
        exp_ovf = 1'b0;
        exp_suc = 1'b0;
        check_all("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        do_op(OP_POP, 0, "pop_after_rst");
        for (int i = 0; i < 300; i++) begin
            int o;
            o = $urandom_range(0, 9);
            do_op(o >= 8 ? OP_PUSH : 3'(o), int'($urandom_range(0, 255)) - 128, "rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
